// File: rtl/wshb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wshb_arb_pkg
// Shared types and constants for the two-master Wishbone classic arbiter.
//   arb_state_t : grant FSM state (idle, owned by a master, draining a master)
//   CTI_*       : Wishbone cycle-type identifiers the arbiter cares about
// ---------------------------------------------------------------------------
package wshb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWN0   = 3'd1,
    OWN1   = 3'd2,
    DRAIN0 = 3'd3,
    DRAIN1 = 3'd4
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_arb_quantum.sv
// ---------------------------------------------------------------------------
// wshb_arb_quantum
// Counts the acks the current owner collects while the other master waits,
// and raises preempt on the ack that brings the count to QUANTUM, provided
// that ack closes a transfer (classic or end-of-burst cycle type).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   active     : a master currently owns the slave (OWN0/OWN1)
//   ack        : slave ack
//   other_req  : the non-owning master holds cyc
//   cti        : owner's cycle-type identifier
//   preempt    : combinational, valid in the cycle of the triggering ack
// ---------------------------------------------------------------------------
module wshb_arb_quantum
  import wshb_arb_pkg::*;
#(
  parameter int QUANTUM = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       ack,
  input  logic       other_req,
  input  logic [2:0] cti,
  output logic       preempt
);

  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cti_closes;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!active || !other_req) begin
      cnt_d = '0;
    end else if (ack && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Bursts (CTI_INCR) are never split; only a transfer-closing ack may preempt.
  assign cti_closes = (cti == CTI_CLASSIC) || (cti == CTI_EOB);

  // Compare against the post-ack count so preemption follows the QUANTUM-th ack
  // directly; a saturated counter keeps the trigger armed until a closing ack.
  assign preempt = active && other_req && ack && cti_closes && (cnt_d == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wshb_arbiter_2.sv
// ---------------------------------------------------------------------------
// wshb_arbiter_2
// Two-master Wishbone classic arbiter in front of a single slave port.
// Master 0 is the latency-critical display reader, master 1 the pattern
// writer. Round-robin on simultaneous requests, bounded share via quantum
// preemption, one idle/drain cycle on every hand-over, no data buffering.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   m0_* / m1_*     : Wishbone master ports (cyc, stb, we, adr, dat_ms, sel,
//                     cti, bte in; dat_sm, ack out)
//   s_*             : Wishbone slave port towards the SDRAM controller
//   grant           : one-hot current owner, 00 when idle
// ---------------------------------------------------------------------------
module wshb_arbiter_2
  import wshb_arb_pkg::*;
#(
  parameter int ADR_W       = 32,
  parameter int DAT_W       = 16,
  parameter int QUANTUM     = 64,
  parameter int START_OWNER = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_ms,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [2:0]         m0_cti,
  input  logic [1:0]         m0_bte,
  output logic [DAT_W-1:0]   m0_dat_sm,
  output logic               m0_ack,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_ms,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [2:0]         m1_cti,
  input  logic [1:0]         m1_bte,
  output logic [DAT_W-1:0]   m1_dat_sm,
  output logic               m1_ack,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_ms,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [2:0]         s_cti,
  output logic [1:0]         s_bte,
  input  logic [DAT_W-1:0]   s_dat_sm,
  input  logic               s_ack,
  output logic [1:0]         grant
);

  localparam logic START_BIT = (START_OWNER != 0);

  arb_state_t state_q;
  logic       last_owner_q;

  logic       own0, own1;
  logic       q_other_req;
  logic [2:0] q_cti;
  logic       preempt;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  assign q_other_req = own0 ? m1_cyc : (own1 ? m0_cyc : 1'b0);
  assign q_cti       = own1 ? m1_cti : m0_cti;

  wshb_arb_quantum #(
    .QUANTUM (QUANTUM)
  ) u_quantum (
    .clk       (clk),
    .rst       (rst),
    .active    (own0 || own1),
    .ack       (s_ack),
    .other_req (q_other_req),
    .cti       (q_cti),
    .preempt   (preempt)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= ~START_BIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc && m1_cyc) begin
            state_q <= last_owner_q ? OWN0 : OWN1;
          end else if (m0_cyc) begin
            state_q <= OWN0;
          end else if (m1_cyc) begin
            state_q <= OWN1;
          end
        end
        // Release has priority over a preemption firing in the same cycle.
        OWN0: begin
          if (!m0_cyc) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
          end else if (preempt) begin
            state_q <= DRAIN0;
          end
        end
        OWN1: begin
          if (!m1_cyc) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
          end else if (preempt) begin
            state_q <= DRAIN1;
          end
        end
        DRAIN0: begin
          state_q      <= OWN1;
          last_owner_q <= 1'b0;
        end
        DRAIN1: begin
          state_q      <= OWN0;
          last_owner_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = {(state_q == OWN1) || (state_q == DRAIN1),
                  (state_q == OWN0) || (state_q == DRAIN0)};

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // In IDLE and DRAINx the slave port is quiet and stray acks are dropped;
  // a drained master keeps stb asserted and simply waits.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
      end
      OWN1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter_2.sv
// ---------------------------------------------------------------------------
// tb_wshb_arbiter_2
// Self-checking bench for wshb_arbiter_2 (QUANTUM=4, START_OWNER=0).
// A table of per-cycle vectors covers basic grant/round-robin behaviour,
// hand-written sequences cover preemption, bursts, reset and stray acks, and
// a randomized phase compares against a transaction-level ownership model.
// ---------------------------------------------------------------------------
module tb_wshb_arbiter_2;
  import wshb_arb_pkg::*;

  localparam int ADR_W   = 32;
  localparam int DAT_W   = 16;
  localparam int SEL_W   = DAT_W / 8;
  localparam int QUANTUM = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             m0_cyc, m0_stb, m0_we, m0_ack;
  logic [ADR_W-1:0] m0_adr;
  logic [DAT_W-1:0] m0_dat_ms, m0_dat_sm;
  logic [SEL_W-1:0] m0_sel;
  logic [2:0]       m0_cti;
  logic [1:0]       m0_bte;
  logic             m1_cyc, m1_stb, m1_we, m1_ack;
  logic [ADR_W-1:0] m1_adr;
  logic [DAT_W-1:0] m1_dat_ms, m1_dat_sm;
  logic [SEL_W-1:0] m1_sel;
  logic [2:0]       m1_cti;
  logic [1:0]       m1_bte;
  logic             s_cyc, s_stb, s_we, s_ack;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_dat_ms, s_dat_sm;
  logic [SEL_W-1:0] s_sel;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic [1:0]       grant;

  // Slave model: zero-wait ack when enabled, plus a forced ack for stray-ack tests.
  logic ack_en, ack_force;
  assign s_ack = (ack_en & s_cyc & s_stb) | ack_force;

  int n_checks = 0;
  int n_err    = 0;

  wshb_arbiter_2 #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .QUANTUM(QUANTUM), .START_OWNER(0)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
    m0_cti = CTI_CLASSIC; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
    m1_cti = CTI_CLASSIC; m1_bte = '0;
    ack_en = 0; ack_force = 0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       c0;
    logic       c1;
    logic       ack_en;
    logic [1:0] grant;
    logic       s_cyc;
    logic       a0;
    logic       a1;
  } vec_t;

  localparam logic [ADR_W-1:0] A0 = 32'h0000_1000;
  localparam logic [ADR_W-1:0] A1 = 32'h0000_2000;

  vec_t             vt [12];
  logic [ADR_W-1:0] exp_adr, stall_adr;
  bit               got, m0_seen;
  int               n_ack;

  // Randomized-phase state: masters and the ownership model.
  bit               ract  [2];
  int               rrem  [2];
  bit               rburst[2];
  logic [ADR_W-1:0] radr  [2];
  logic [2:0]       rcti  [2];
  bit               rpa   [2];
  bit               ea    [2];
  int               own, qcnt;
  bit               drain, last;
  logic [1:0]       ex_grant;
  bit               ex_scyc;

  initial begin
    clear_inputs();
    s_dat_sm = 16'hA55A;
    rst = 1;
    ack_force = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_adr", s_adr, 0);
    check("rst_m0_ack", m0_ack, 0);
    check("rst_m1_ack", m1_ack, 0);
    @(negedge clk);
    rst = 0;
    ack_force = 0;

    // ---- table: grant latency, release, round-robin ----
    vt[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    m0_adr = A0;
    m1_adr = A1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m0_cyc = vt[i].c0; m0_stb = vt[i].c0;
      m1_cyc = vt[i].c1; m1_stb = vt[i].c1;
      ack_en = vt[i].ack_en;
      s_dat_sm = DAT_W'(16'h1000 + i);
      #1;
      exp_adr = (vt[i].grant == 2'b01) ? A0 : ((vt[i].grant == 2'b10) ? A1 : '0);
      check($sformatf("tbl%0d_grant", i), grant, vt[i].grant);
      check($sformatf("tbl%0d_s_cyc", i), s_cyc, vt[i].s_cyc);
      check($sformatf("tbl%0d_s_stb", i), s_stb, vt[i].s_cyc);
      check($sformatf("tbl%0d_m0_ack", i), m0_ack, vt[i].a0);
      check($sformatf("tbl%0d_m1_ack", i), m1_ack, vt[i].a1);
      check($sformatf("tbl%0d_s_adr", i), s_adr, exp_adr);
      check($sformatf("tbl%0d_m0_dat", i), m0_dat_sm, DAT_W'(16'h1000 + i));
      check($sformatf("tbl%0d_m1_dat", i), m1_dat_sm, DAT_W'(16'h1000 + i));
    end
    go_idle();

    // ---- single master 1 writes 10 words ----
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0100; ack_en = 1;
    #1;
    check("s1_latency", grant, 2'b00);
    got = 0; n_ack = 0; m0_seen = 0;
    for (int c = 0; c < 40 && n_ack < 10; c++) begin
      @(negedge clk);
      if (got) m1_adr = m1_adr + 1;
      #1;
      if (c == 0) check("s1_grant", grant, 2'b10);
      if (c == 0) check("s1_s_we", s_we, 1);
      got = m1_ack;
      if (got) n_ack++;
      if (m0_ack) m0_seen = 1;
    end
    check("s1_ack_count", n_ack, 10);
    check("s1_m0_ack_seen", m0_seen, 0);
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0;
    #1;
    check("s1_rel_grant", grant, 2'b10);
    @(negedge clk); #1;
    check("s1_idle_grant", grant, 2'b00);
    go_idle();

    // ---- quantum preemption of streaming master 1 ----
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_3000; ack_en = 1;
    @(negedge clk); #1;
    got = m1_ack;
    n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (got) m1_adr = m1_adr + 1;
      if (c == 0) begin
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_4000;
      end
      #1;
      if (grant != 2'b10 || !s_cyc) break;
      got = m1_ack;
      if (got) n_ack++;
    end
    check("pre_m1_acks", n_ack, QUANTUM);
    check("drain1_grant", grant, 2'b10);
    check("drain1_s_cyc", s_cyc, 0);
    check("drain1_m1_ack", m1_ack, 0);
    stall_adr = m1_adr;
    @(negedge clk); #1;
    check("pre_own0_grant", grant, 2'b01);
    check("pre_own0_adr", s_adr, 32'h0000_4000);
    check("pre_own0_ack", m0_ack, 1);
    check("pre_own0_m1_ack", m1_ack, 0);
    @(negedge clk);
    m0_adr = 32'h0000_4001;
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    #1;
    check("pre_rel_grant", grant, 2'b01);
    @(negedge clk); #1;
    check("pre_idle_grant", grant, 2'b00);
    @(negedge clk); #1;
    check("pre_regrant", grant, 2'b10);
    check("pre_resume_adr", s_adr, stall_adr);
    check("pre_resume_ack", m1_ack, 1);
    go_idle();

    // ---- 8-beat incrementing burst is not split ----
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_6000; m1_cti = CTI_INCR;
    ack_en = 1;
    got = 0; n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (got) m1_adr = m1_adr + 1;
      if (c == 0) begin
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_7000;
      end
      if (n_ack == 8) begin
        m1_cyc = 0; m1_stb = 0;
      end
      m1_cti = (n_ack == 7) ? CTI_EOB : CTI_INCR;
      #1;
      if (grant != 2'b10 || !s_cyc) break;
      got = m1_ack;
      if (got) n_ack++;
    end
    check("burst_acks", n_ack, 8);
    check("burst_drain_grant", grant, 2'b10);
    check("burst_drain_s_cyc", s_cyc, 0);
    @(negedge clk); #1;
    check("burst_own0_grant", grant, 2'b01);
    go_idle();

    // ---- synchronous reset during OWN0 ----
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_8000; ack_en = 1;
    @(negedge clk); #1;
    check("rstmid_own0", grant, 2'b01);
    @(negedge clk);
    rst = 1;
    #1;
    check("rstmid_sync", s_cyc, 1);
    @(negedge clk);
    rst = 0;
    #1;
    check("rstmid_s_cyc", s_cyc, 0);
    check("rstmid_s_stb", s_stb, 0);
    check("rstmid_grant", grant, 2'b00);
    check("rstmid_m0_ack", m0_ack, 0);
    @(negedge clk); #1;
    check("rstmid_regrant", grant, 2'b01);
    go_idle();

    // ---- stray acks in IDLE and DRAIN0 ----
    @(negedge clk);
    ack_force = 1;
    #1;
    check("stray_idle_m0", m0_ack, 0);
    check("stray_idle_m1", m1_ack, 0);
    check("stray_idle_grant", grant, 2'b00);
    @(negedge clk);
    ack_force = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_9000; ack_en = 1;
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_A000;
    #1;
    got = m0_ack;
    n_ack = got ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (got) m0_adr = m0_adr + 1;
      #1;
      if (grant != 2'b01 || !s_cyc) break;
      got = m0_ack;
      if (got) n_ack++;
    end
    check("drain0_m0_acks", n_ack, QUANTUM);
    ack_force = 1;
    #1;
    check("stray_drain_grant", grant, 2'b01);
    check("stray_drain_s_cyc", s_cyc, 0);
    check("stray_drain_m0", m0_ack, 0);
    check("stray_drain_m1", m1_ack, 0);
    @(negedge clk);
    ack_force = 0;
    #1;
    check("drain0_own1", grant, 2'b10);
    go_idle();

    // ---- randomized traffic against the ownership model ----
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    own = -1; qcnt = 0; drain = 0; last = 1;
    for (int m = 0; m < 2; m++) begin
      ract[m] = 0; rrem[m] = 0; rburst[m] = 0; rpa[m] = 0;
      radr[m] = ADR_W'(32'h0001_0000 * (m + 1));
      rcti[m] = CTI_CLASSIC;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (ract[m] && rpa[m]) begin
          radr[m] = radr[m] + 1;
          rrem[m] = rrem[m] - 1;
          if (rrem[m] == 0) ract[m] = 0;
        end else if (!ract[m] && $urandom_range(0, 2) == 0) begin
          ract[m]   = 1;
          rrem[m]   = int'($urandom_range(1, 6));
          rburst[m] = ($urandom_range(0, 1) == 1);
        end
        rcti[m] = !rburst[m] ? CTI_CLASSIC : ((rrem[m] == 1) ? CTI_EOB : CTI_INCR);
      end
      m0_cyc = ract[0]; m0_stb = ract[0]; m0_adr = radr[0]; m0_cti = rcti[0];
      m0_we = 1'($urandom); m0_dat_ms = DAT_W'($urandom);
      m1_cyc = ract[1]; m1_stb = ract[1]; m1_adr = radr[1]; m1_cti = rcti[1];
      m1_we = 1'($urandom); m1_dat_ms = DAT_W'($urandom);
      ack_en = ($urandom_range(0, 3) != 0);
      #1;
      ex_grant = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);
      ex_scyc  = 0;
      if (own >= 0 && !drain) ex_scyc = ract[own];
      for (int m = 0; m < 2; m++) ea[m] = ex_scyc && (own == m) && ack_en;
      check("rnd_grant", grant, ex_grant);
      check("rnd_s_cyc", s_cyc, ex_scyc);
      check("rnd_m0_ack", m0_ack, ea[0]);
      check("rnd_m1_ack", m1_ack, ea[1]);
      if (ex_scyc) check("rnd_s_adr", s_adr, radr[own]);
      // Ownership rules applied at the coming clock edge.
      if (own < 0) begin
        qcnt = 0;
        if (ract[0] && ract[1]) own = last ? 0 : 1;
        else if (ract[0]) own = 0;
        else if (ract[1]) own = 1;
      end else if (drain) begin
        last = (own == 1); own = 1 - own; drain = 0; qcnt = 0;
      end else if (!ract[own]) begin
        last = (own == 1); own = -1; qcnt = 0;
      end else if (!ract[1-own]) begin
        qcnt = 0;
      end else if (ea[own]) begin
        if (qcnt < QUANTUM) qcnt++;
        if (qcnt == QUANTUM && (rcti[own] == CTI_CLASSIC || rcti[own] == CTI_EOB)) drain = 1;
      end
      rpa[0] = ea[0];
      rpa[1] = ea[1];
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
